// File: rtl/alu_pipe_issue_ctrl.sv
// alu_pipe_issue_ctrl
//
// Issue-side driver and result collector for the 3-stage pipelined ALU.
//
// Ops arrive on a valid/ready handshake. Each part of the control word is
// delivered to the ALU in the stage that uses it:
//   - alu_ctrl[7:4] goes out in the issue cycle, together with the operands.
//   - alu_ctrl[2:0] goes out one active cycle later.
//   - alu_ctrl[3] and alu_cin go out two active cycles later.
//
// A valid/tag shift register runs in lock-step with the ALU stages. The ALU
// results, tagged, are presented on a valid/ready output handshake that
// supports full backpressure. The whole pipe advances only when the output
// stage is empty or is being drained.
//
// Ports:
//   clk, reset_n              clock; synchronous active-low reset
//   in_valid/in_ready         op handshake (in_ready is combinational from out_ready)
//   in_a, in_b                operands
//   in_ctrl, in_cin, in_tag   control word, carry-in and destination tag of the op
//   flush                     synchronous kill of every in-flight op
//   alu_a, alu_b              operands to the ALU (zero when no op is issued)
//   alu_ctrl, alu_cin         control word and carry-in to the ALU, skewed per stage
//   alu_pipe_active           ALU pipeline enable
//   alu_out, alu_cout         ALU result and carry-out
//   out_valid/out_ready       result handshake
//   out_data, out_cout        result, passed through from the ALU
//   out_tag                   tag of the result
//
// Optional build macro ALU_PIPE_ISSUE_STATS_EN adds three 32-bit wrapping
// counters: stat_issued, stat_retired and stat_stall. All three clear on
// reset and on flush.
module alu_pipe_issue_ctrl #(
   parameter int REG_WIDTH  = 16,
   parameter int TAG_WIDTH  = 4,
   parameter int PIPE_DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_WIDTH-1:0] in_a,
   input  logic [REG_WIDTH-1:0] in_b,
   input  logic [7:0]           in_ctrl,
   input  logic                 in_cin,
   input  logic [TAG_WIDTH-1:0] in_tag,
   input  logic                 flush,
   output logic [REG_WIDTH-1:0] alu_a,
   output logic [REG_WIDTH-1:0] alu_b,
   output logic [7:0]           alu_ctrl,
   output logic                 alu_cin,
   output logic                 alu_pipe_active,
   input  logic [REG_WIDTH-1:0] alu_out,
   input  logic                 alu_cout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_WIDTH-1:0] out_data,
   output logic                 out_cout,
   output logic [TAG_WIDTH-1:0] out_tag
`ifdef ALU_PIPE_ISSUE_STATS_EN
   ,
   output logic [31:0]          stat_issued,
   output logic [31:0]          stat_retired,
   output logic [31:0]          stat_stall
`endif
);

   // The skew and tracking structure below is hard-wired for three ALU stages.
   if (PIPE_DEPTH != 3) begin : g_depth_check
      $error("alu_pipe_issue_ctrl: PIPE_DEPTH must be 3");
   end

   logic                 adv;
   logic                 accept;
   logic                 vld_p0, vld_p1, vld_p2;
   logic [TAG_WIDTH-1:0] tag_p0, tag_p1, tag_p2;
   logic [2:0]           ctrl_lo_p1;
   logic                 ctrl_b3_p1, cin_p1;
   logic                 ctrl_b3_p2, cin_p2;

   // The pipe stalls only when the output stage holds a result that is not
   // being taken. A bubble in any earlier stage never stalls the pipe.
   assign adv             = ~vld_p2 | out_ready;
   assign alu_pipe_active = ~reset_n | adv;
   assign in_ready        = ~reset_n | (adv & ~flush);
   // Ops offered while the block is in reset are dropped.
   assign accept          = reset_n & in_valid & in_ready;

   // Stage 0 (issue): operands and ctrl[7:4] go straight through to the ALU.
   assign alu_a    = accept ? in_a : '0;
   assign alu_b    = accept ? in_b : '0;
   assign alu_ctrl = {(accept ? in_ctrl[7:4] : 4'h0), ctrl_b3_p2, ctrl_lo_p1};
   assign alu_cin  = cin_p2;

   assign out_valid = vld_p2;
   assign out_tag   = tag_p2;
   assign out_data  = alu_out;
   assign out_cout  = alu_cout;

   // Valid bits and skew registers. A flush clears these even while the pipe
   // is stalled, so that nothing issued before the flush can resurface.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         ctrl_lo_p1 <= 3'b000;
         ctrl_b3_p1 <= 1'b0;
         cin_p1     <= 1'b0;
         ctrl_b3_p2 <= 1'b0;
         cin_p2     <= 1'b0;
      end else if (adv) begin
         vld_p0     <= accept;
         vld_p1     <= vld_p0;
         vld_p2     <= vld_p1;
         // Stage 1: ctrl[2:0] is consumed here. ctrl[3] and cin move one stage on.
         ctrl_lo_p1 <= accept ? in_ctrl[2:0] : 3'b000;
         ctrl_b3_p1 <= accept & in_ctrl[3];
         cin_p1     <= accept & in_cin;
         // Stage 2: ctrl[3] and cin are consumed here.
         ctrl_b3_p2 <= ctrl_b3_p1;
         cin_p2     <= cin_p1;
      end
   end

   // Tags travel with the valid bits. The valid bits alone decide whether a
   // tag is meaningful, so a flush does not need to clear the tags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tag_p0 <= '0;
         tag_p1 <= '0;
         tag_p2 <= '0;
      end else if (adv) begin
         tag_p0 <= in_tag;
         tag_p1 <= tag_p0;
         tag_p2 <= tag_p1;
      end
   end

`ifdef ALU_PIPE_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         stat_issued  <= '0;
         stat_retired <= '0;
         stat_stall   <= '0;
      end else begin
         if (accept)
            stat_issued <= stat_issued + 32'd1;
         if (vld_p2 && out_ready)
            stat_retired <= stat_retired + 32'd1;
         if (vld_p2 && !out_ready)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
